// File: rtl/iob_norm_pkg.sv
`default_nettype none
// ==== iob_norm_pkg : shared helpers and payload layout for the normaliser | rev 1.0 ====

package iob_norm_pkg;

  localparam int NORM_EXP_W  = 8;
  localparam int NORM_DATA_W = 32;
  localparam int NORM_BW     = $clog2(NORM_DATA_W);

  function automatic int stage_count(input int data_w);
    return $clog2(data_w);
  endfunction

  function automatic int exp_min(input int exp_w);
    return -(1 << (exp_w - 1));
  endfunction

  // Payload at the default widths; the top builds the same layout at its own widths.
  typedef struct packed {
    logic                   valid;
    logic                   zero;
    logic                   uflow;
    logic [NORM_BW-1:0]     budget;
    logic [NORM_EXP_W-1:0]  exp;
    logic [NORM_DATA_W-1:0] man;
  } norm_payload_t;

endpackage

`default_nettype wire

// File: rtl/iob_norm_stage.sv
`default_nettype none
// ==== iob_norm_stage : one combinational normalise step of fixed shift SHIFT | rev 1.0 ====

module iob_norm_stage
  import iob_norm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int BW     = 5,
  parameter int SHIFT  = 1,
  parameter bit LAST   = 1'b0
) (
  input  logic              valid,
  input  logic              zero,
  input  logic [BW-1:0]     budget,
  input  logic [EXP_W-1:0]  exp,
  input  logic [DATA_W-1:0] man,
  output logic              nxt_valid,
  output logic              nxt_zero,
  output logic              nxt_uflow,
  output logic [BW-1:0]     nxt_budget,
  output logic [EXP_W-1:0]  nxt_exp,
  output logic [DATA_W-1:0] nxt_man
);

  logic take;

  assign take       = (man[DATA_W-1 -: SHIFT] == '0) && (budget >= BW'(SHIFT));
  assign nxt_valid  = valid;
  assign nxt_zero   = zero;
  assign nxt_man    = take ? (man << SHIFT) : man;
  assign nxt_exp    = take ? (exp - EXP_W'(SHIFT)) : exp;
  assign nxt_budget = take ? (budget - BW'(SHIFT)) : budget;

  generate
    if (LAST) begin : g_last
      // A nonzero mantissa still lacking its MSB here means the budget ran out first.
      assign nxt_uflow = valid & ~zero & ~nxt_man[DATA_W-1] & (nxt_budget == '0);
    end else begin : g_mid
      assign nxt_uflow = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/iob_norm_pipe.sv
`default_nettype none
// ==== iob_norm_pipe : pipelined handshaked mantissa normaliser with exponent floor | rev 1.0 ====

module iob_norm_pipe
  import iob_norm_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [DATA_W-1:0] man_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [EXP_W-1:0]  exp_o,
  output logic [DATA_W-1:0] man_o,
  output logic              zero_o,
  output logic              uflow_o
);

  localparam int NSTG = stage_count(DATA_W);
  localparam int BW   = NSTG;
  localparam logic [EXP_W-1:0] EMIN = EXP_W'(exp_min(EXP_W));

  typedef struct packed {
    logic              valid;
    logic              zero;
    logic              uflow;
    logic [BW-1:0]     budget;
    logic [EXP_W-1:0]  exp;
    logic [DATA_W-1:0] man;
  } stage_t;

  logic              stall;
  logic              ent_zero;
  logic [EXP_W:0]    bud_full;
  logic [BW-1:0]     bud_sat;
  logic [BW-1:0]     ent_budget;
  logic [EXP_W-1:0]  ent_exp;

  stage_t src [NSTG];
  stage_t d   [NSTG];
  stage_t q   [NSTG];

  // exp - EXP_MIN is the exponent with its sign bit flipped, read unsigned.
  assign bud_full = {1'b0, ~exp_i[EXP_W-1], exp_i[EXP_W-2:0]};

  generate
    if (EXP_W + 1 > BW) begin : g_sat
      assign bud_sat = (|bud_full[EXP_W:BW]) ? '1 : bud_full[BW-1:0];
    end else begin : g_nosat
      assign bud_sat = BW'(bud_full);
    end
  endgenerate

  // A zero mantissa enters already at EXP_MIN with no budget, so no stage moves it.
  assign ent_zero   = (man_i == '0);
  assign ent_budget = ent_zero ? '0 : bud_sat;
  assign ent_exp    = ent_zero ? EMIN : exp_i;

  assign src[0] = {valid_i, ent_zero, 1'b0, ent_budget, ent_exp, man_i};

  genvar i;
  generate
    for (i = 0; i < NSTG; i++) begin : g_stage
      logic              n_valid;
      logic              n_zero;
      logic              n_uflow;
      logic [BW-1:0]     n_budget;
      logic [EXP_W-1:0]  n_exp;
      logic [DATA_W-1:0] n_man;

      if (i > 0) begin : g_link
        assign src[i] = q[i-1];
      end

      iob_norm_stage #(
        .DATA_W (DATA_W),
        .EXP_W  (EXP_W),
        .BW     (BW),
        .SHIFT  (1 << (NSTG - 1 - i)),
        .LAST   (i == NSTG - 1)
      ) u_stage (
        .valid      (src[i].valid),
        .zero       (src[i].zero),
        .budget     (src[i].budget),
        .exp        (src[i].exp),
        .man        (src[i].man),
        .nxt_valid  (n_valid),
        .nxt_zero   (n_zero),
        .nxt_uflow  (n_uflow),
        .nxt_budget (n_budget),
        .nxt_exp    (n_exp),
        .nxt_man    (n_man)
      );

      assign d[i] = {n_valid, n_zero, n_uflow, n_budget, n_exp, n_man};
    end
  endgenerate

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int j = 0; j < NSTG; j++) q[j] <= '0;
    end else if (!stall) begin
      for (int j = 0; j < NSTG; j++) q[j] <= d[j];
    end
  end

  assign valid_o = q[NSTG-1].valid;
  assign exp_o   = q[NSTG-1].exp;
  assign man_o   = q[NSTG-1].man;
  assign zero_o  = q[NSTG-1].zero;
  assign uflow_o = q[NSTG-1].uflow;
  assign stall   = valid_o & ~ready_i;
  assign ready_o = ~stall;

endmodule

`default_nettype wire

// File: tb/tb_iob_norm_pipe.sv
`default_nettype none
// ==== tb_iob_norm_pipe : randomized self-checking bench for iob_norm_pipe | rev 1.0 ====

module tb_iob_norm_pipe;
  import iob_norm_pkg::*;

  localparam int EXP_W  = 8;
  localparam int DATA_W = 32;
  localparam int NSTG   = 5;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic              valid_i = 1'b0;
  logic              ready_i = 1'b1;
  logic [EXP_W-1:0]  exp_i = '0;
  logic [DATA_W-1:0] man_i = '0;
  logic              ready_o, valid_o, zero_o, uflow_o;
  logic [EXP_W-1:0]  exp_o;
  logic [DATA_W-1:0] man_o;

  iob_norm_pipe #(.EXP_W(EXP_W), .DATA_W(DATA_W)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .exp_i    (exp_i),
    .man_i    (man_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .exp_o    (exp_o),
    .man_o    (man_o),
    .zero_o   (zero_o),
    .uflow_o  (uflow_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int seen_out = 0;
  bit lat_mode = 1'b0;

  norm_payload_t exp_q[$];
  int            acc_q[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: shift = min(leading zeros, exp - EXP_MIN), exponent floored at -128.
  function automatic norm_payload_t ref_norm(input logic [7:0] e, input logic [31:0] m);
    norm_payload_t r;
    int lz, b, s;
    r = '0;
    r.valid = 1'b1;
    if (m == 0) begin
      r.zero = 1'b1;
      r.exp  = 8'h80;
      return r;
    end
    lz = 0;
    while (!m[31-lz]) lz++;
    b = $signed(e) + 128;
    s = (lz < b) ? lz : b;
    r.man   = m << s;
    r.exp   = 8'($signed(e) - s);
    r.uflow = (s < lz);
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: model on input handshake, compare on output handshake, stall behaviour.
  initial begin
    logic              stalled_prev;
    logic [DATA_W-1:0] prev_man;
    logic [EXP_W-1:0]  prev_exp;
    norm_payload_t     r;
    int                a;
    stalled_prev = 1'b0;
    prev_man = '0;
    prev_exp = '0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        stalled_prev = 1'b0;
      end else begin
        check_val("ready_o", ready_o, !(valid_o && !ready_i));
        if (stalled_prev) begin
          check_val("hold_valid", valid_o, 1);
          check_val("hold_man", man_o, prev_man);
          check_val("hold_exp", exp_o, prev_exp);
        end
        if (valid_i && ready_o) begin
          exp_q.push_back(ref_norm(exp_i, man_i));
          acc_q.push_back(cyc);
        end
        if (valid_o && ready_i) begin
          seen_out++;
          if (exp_q.size() == 0) begin
            check_val("unexpected_out", valid_o, 0);
          end else begin
            r = exp_q.pop_front();
            a = acc_q.pop_front();
            check_val("man", man_o, r.man);
            check_val("exp", exp_o, r.exp);
            check_val("zero", zero_o, r.zero);
            check_val("uflow", uflow_o, r.uflow);
            if (lat_mode) check_val("latency", cyc - a, NSTG);
          end
        end
        stalled_prev = valid_o && !ready_i;
        prev_man = man_o;
        prev_exp = exp_o;
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that captured the operand.
  task automatic send(input logic [7:0] e, input logic [31:0] m);
    logic ok;
    int n;
    exp_i = e;
    man_i = m;
    valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    if (!ok) check_val("send_timeout", ok, 1);
  endtask

  task automatic directed(input logic [7:0] e, input logic [31:0] m, input logic [31:0] xm,
                          input logic [7:0] xe, input logic xz, input logic xu);
    int n;
    send(e, m);
    valid_i = 1'b0;
    n = 0;
    @(negedge clk);
    while (!valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("dir_valid", valid_o, 1);
    check_val("dir_man", man_o, xm);
    check_val("dir_exp", exp_o, xe);
    check_val("dir_zero", zero_o, xz);
    check_val("dir_uflow", uflow_o, xu);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    #1;
    check_val("rst_valid", valid_o, 0);
    check_val("rst_ready", ready_o, 1);
    check_val("rst_man", man_o, 0);
    check_val("rst_exp", exp_o, 0);
    check_val("rst_zero", zero_o, 0);
    check_val("rst_uflow", uflow_o, 0);
    repeat (3) @(posedge clk);
    #1;
    arst_n = 1'b1;
    @(posedge clk);
    #1;

    lat_mode = 1'b1;
    directed(8'd10,   32'h0000_1000, 32'h8000_0000, 8'hF7, 1'b0, 1'b0);
    directed(8'h88,   32'h0000_1000, 32'h0010_0000, 8'h80, 1'b0, 1'b1);
    directed(8'd37,   32'h0000_0000, 32'h0000_0000, 8'h80, 1'b1, 1'b0);
    directed(8'd5,    32'h8000_0001, 32'h8000_0001, 8'd5,  1'b0, 1'b0);
    directed(8'd127,  32'h0000_0001, 32'h8000_0000, 8'd96, 1'b0, 1'b0);
    directed(8'h80,   32'h0000_0003, 32'h0000_0003, 8'h80, 1'b0, 1'b1);
    lat_mode = 1'b0;

    // Random back-to-back stream with a 3-cycle downstream stall.
    base = seen_out;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          logic [31:0] r;
          int sh;
          r  = $urandom;
          sh = $urandom_range(0, 32);
          send(8'($urandom_range(0, 255)), (sh == 32) ? 32'h0 : ((r | 32'h8000_0000) >> sh));
        end
        valid_i = 1'b0;
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    repeat (2 * NSTG + 5) @(posedge clk);
    #1;
    check_val("stream_count", seen_out - base, 20);
    check_val("stream_drained", exp_q.size(), 0);

    // Reset with three operands in flight.
    send(8'd20, 32'h0000_00F0);
    send(8'd3,  32'h0001_0000);
    ready_i = 1'b0;
    send(8'd90, 32'h0000_0001);
    valid_i = 1'b0;
    n = 0;
    while (!valid_o && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("inflight_valid", valid_o, 1);
    arst_n = 1'b0;
    #1;
    check_val("arst_valid", valid_o, 0);
    check_val("arst_ready", ready_o, 1);
    check_val("arst_man", man_o, 0);
    exp_q.delete();
    acc_q.delete();
    ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    base = seen_out;
    repeat (3 * NSTG) @(posedge clk);
    #1;
    check_val("post_rst_outputs", seen_out - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/iob_norm_pipe.md
# iob_norm_pipe

Pipelined, handshaked floating-point normaliser. It shifts a mantissa left until its MSB is set and subtracts the shift from a signed exponent, treating the exponent as two's complement. When a full shift would take the exponent below its minimum, the shift is limited and an underflow is flagged (denormal result). The block sits between the add/multiply datapath and the rounding/packing stage of the pt-float units, replacing the single-cycle combinational normaliser on wide or high-frequency configurations.

## Interface
- EXP_W, 8, exponent width; two's complement; EXP_MIN = -2^(EXP_W-1).
- DATA_W, 32, mantissa width; must be ≥ 4.
- NSTG, derived = $clog2(DATA_W), number of shift stages and pipeline latency.

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  input operand valid.
- ready_o  out  1  block can accept an input this cycle.
- exp_i  in  EXP_W  signed exponent.
- man_i  in  DATA_W  unsigned mantissa.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts the result.
- exp_o  out  EXP_W  normalised exponent.
- man_o  out  DATA_W  normalised mantissa.
- zero_o  out  1  input mantissa was zero.
- uflow_o  out  1  shift was limited by EXP_MIN.

## Operation
- Budget B = exp_i - EXP_MIN is computed at entry in EXP_W+1 bits and saturated to 2^NSTG - 1.
- Stage k runs for k = NSTG-1 down to 0. If the top 2^k mantissa bits are zero and the remaining B ≥ 2^k, then:
  - mantissa shifts left by 2^k;
  - exponent and B each decrease by 2^k.
- Total shift S = min(leading zeros of man_i, B). The greedy largest-first order guarantees this.
- uflow_o = 1 iff man_i ≠ 0 and S < leading zeros of man_i. In that case exp_o = EXP_MIN.
- Zero input (man_i = 0): man_o = 0, exp_o = EXP_MIN, zero_o = 1, uflow_o = 0. exp_i is ignored.
- Already-normalised input (MSB set): S = 0, outputs equal inputs.
- Exponent arithmetic never wraps. A result below EXP_MIN is impossible by construction.

## Timing
- One register bank after each stage. Latency is exactly NSTG cycles from handshake to valid_o when there is no stall.
- Throughput is one operand per cycle.
- Global stall: stall = valid_o & ~ready_i. ready_o = ~stall.
- During a stall:
  - all stage registers hold;
  - outputs stay stable;
  - inputs offered while ready_o = 0 are not captured.
- Bubbles (valid_i = 0) propagate as per-stage valid bits. They never stall the pipe.
- Input and output handshakes in the same cycle are legal and lossless.
- Reset (asynchronous assert, synchronous deassert in the surrounding logic):
  - all stage valid bits clear, so valid_o = 0;
  - exp_o = 0, man_o = 0, zero_o = 0, uflow_o = 0;
  - ready_o = 1 after reset.
- Reset mid-operation discards every in-flight operand. No output is produced for them.

## Structure
- Package iob_norm_pkg holds:
  - the stage-count function (clog2 of DATA_W);
  - the EXP_MIN constant function;
  - a stage payload struct {valid, zero, uflow, budget, exp, man}.
- Sub-module iob_norm_stage is one combinational shift step parametrised by shift amount 2^k. The top level instantiates it NSTG times with registers between instances.
- Zero detection runs at entry and travels down the pipe. The uflow decision is made in the last stage by comparing the residual leading-zero test against the exhausted budget.

## Test plan
All scenarios use DATA_W = 32, EXP_W = 8.
- man 0x0000_1000, exp 10 -> after 5 cycles man 0x8000_0000, exp -9, zero 0, uflow 0.
- man 0x0000_1000, exp -120 -> man 0x0010_0000, exp -128, uflow 1.
- man 0x0000_0000, exp 37 -> man 0, exp -128, zero 1, uflow 0.
- man 0x8000_0001, exp 5 -> unchanged, uflow 0. man 0x0000_0001, exp 127 -> man 0x8000_0000, exp 96.
- Back-to-back stream of 20 random operands with ready_i low for 3 cycles mid-stream -> ready_o low exactly while stalled, outputs held, all 20 results in order and matching the model.
- Assert arst_n_i with 3 operands in flight -> valid_o drops immediately, and none of those 3 results appears after release.
